// File: rtl/imem_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory fetch/load controller.
// Contents: controller state enum, beat constants, fetch address legality check.
// Used by imem_fetch_arbiter; no ports.
package imem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DONE,
    S_ERR,
    S_LOAD
  } state_t;

  // A fetch is four byte beats, most significant byte first.
  localparam int BEATS = 4;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  // True when a fetch address cannot be served: not word aligned, or the
  // four bytes would run past the end of a memory of 'depth' bytes.
  function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                          input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || (addr > depth - 32'(BEATS));
  endfunction

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, last-grant flag updates on a grant edge.
// Ports: clk, rst_n (sync, active-low), req[1:0] (0=fetch, 1=loader), en (arbitration allowed), gnt[1:0].
// Latency 0 cycles; no backpressure of its own, gnt is simply held low while en=0.
module imem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // lg: requester granted last (0=fetch, 1=loader). Resets to loader so
  // that fetch wins the first tie.
  logic lg;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = lg ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    lg <= 1'b1;
    else if (|gnt) lg <= gnt[1];
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Owns the byte-wide instruction memory port, sharing it between 4-beat word fetches and byte loads.
// Ports: CLK/RST_n (sync active-low); fetch_req/addr/ready, instr_out/valid, fetch_err; ld_req/addr/data/ack; mem_*.
// Latency: word 5 cycles after accept (1 on a buffer hit with IMEM_FETCH_CACHE_EN); requesters hold until their pulse.
module imem_fetch_arbiter
  import imem_ctrl_pkg::*;
#(
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_ready,
  output logic [31:0]   instr_out,
  output logic          instr_valid,
  output logic          fetch_err,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  state_t        state, state_n;
  logic [1:0]    beat;
  logic [AW-1:0] base;
  logic [31:0]   word;
  logic [AW-1:0] ld_addr_q;
  logic [7:0]    ld_data_q;
  logic [1:0]    gnt;
  logic          addr_bad;
  logic          hit;
  logic [4:0]    lane_lsb;

  imem_rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RST_n),
    .req   ({ld_req, fetch_req}),
    .en    (state == S_IDLE),
    .gnt   (gnt)
  );

  assign addr_bad = fetch_addr_bad(fetch_addr, 32'(DEPTH));
  // Beat n fills lane 3-n, i.e. bits [8*(3-n) +: 8].
  assign lane_lsb = {~beat, 3'b000};

`ifdef IMEM_FETCH_CACHE_EN
  logic          c_vld;
  logic [AW-1:0] c_tag;
  logic [31:0]   c_word;

  // Only meaningful for a legal address; illegal ones are routed to ERR first.
  assign hit = c_vld && (fetch_addr[AW-1:0] == c_tag);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      c_vld  <= 1'b0;
      c_tag  <= '0;
      c_word <= '0;
    end else if (state == S_FETCH && beat == LAST_BEAT) begin
      c_vld  <= 1'b1;
      c_tag  <= base;
      c_word <= {word[31:8], mem_rdata};
    end else if (state == S_LOAD && ld_addr_q[AW-1:2] == c_tag[AW-1:2]) begin
      // A write anywhere inside the buffered word makes it stale.
      c_vld <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    fetch_ready = 1'b0;
    instr_out   = '0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    ld_ack      = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (state)
      S_IDLE: begin
        if (gnt[0]) begin
          fetch_ready = 1'b1;
          if (addr_bad) state_n = S_ERR;
          else if (hit) state_n = S_DONE;
          else          state_n = S_FETCH;
        end else if (gnt[1]) begin
          state_n = S_LOAD;
        end
      end
      S_FETCH: begin
        mem_addr = base + AW'(beat);
        if (beat == LAST_BEAT) state_n = S_DONE;
      end
      S_DONE: begin
        instr_valid = 1'b1;
        instr_out   = word;
        state_n     = S_IDLE;
      end
      S_ERR: begin
        fetch_err = 1'b1;
        state_n   = S_IDLE;
      end
      S_LOAD: begin
        mem_we    = 1'b1;
        mem_addr  = ld_addr_q;
        mem_wdata = ld_data_q;
        ld_ack    = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state     <= S_IDLE;
      beat      <= '0;
      base      <= '0;
      word      <= '0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && gnt[0]) begin
        base <= fetch_addr[AW-1:0];
        beat <= '0;
`ifdef IMEM_FETCH_CACHE_EN
        if (!addr_bad && hit) word <= c_word;
`endif
      end
      if (state == S_IDLE && gnt[1]) begin
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end
      if (state == S_FETCH) begin
        word[lane_lsb +: 8] <= mem_rdata;
        beat                <= beat + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench: directed scenarios plus randomized fetch/load traffic against a transaction-level model.
// Ports: none; drives imem_fetch_arbiter and a behavioural byte memory.
// Inputs driven 1ns after the rising edge, outputs compared on the falling edge.
module tb_imem_fetch_arbiter;

  localparam int AW    = 7;
  localparam int DEPTH = 128;
`ifdef IMEM_FETCH_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_ready;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic          fetch_err;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  always #5 CLK = ~CLK;

  imem_fetch_arbiter #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_out(instr_out), .instr_valid(instr_valid), .fetch_err(fetch_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Device memory seen by the DUT: asynchronous read, write on the edge.
  logic [7:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // The port is either free or committed to one operation for a fixed
  // number of remaining cycles; the final cycle carries the pulse.
  localparam int K_WORD = 0, K_ERR = 1, K_LOAD = 2;
  logic [7:0]    shadow [DEPTH];
  int            m_busy, m_kind, m_last;
  logic [AW-1:0] m_base, m_ld_addr;
  logic [7:0]    m_ld_data;
  logic [31:0]   m_word;
  bit            c_vld;
  logic [AW-1:0] c_addr;

  function automatic logic [31:0] word_at(input int a);
    return {shadow[a], shadow[a+1], shadow[a+2], shadow[a+3]};
  endfunction

  function automatic bit illegal(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) + 4 > DEPTH);
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_kind = K_WORD; m_last = 1; c_vld = 0;
  endfunction

  logic        saw_ready, saw_valid, saw_err, saw_ack;
  logic [31:0] saw_out;
  int          n_step = 0;

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int winner;
    logic e_ready, e_valid, e_err, e_ack;
    logic [31:0] e_addr, e_wdata, e_out;
    @(negedge CLK);
    winner = -1;
    if (m_busy == 0) begin
      if (fetch_req && ld_req) winner = (m_last == 1) ? 0 : 1;
      else if (fetch_req)      winner = 0;
      else if (ld_req)         winner = 1;
    end
    e_ready = (winner == 0);
    e_valid = (m_busy == 1 && m_kind == K_WORD);
    e_err   = (m_busy == 1 && m_kind == K_ERR);
    e_ack   = (m_busy == 1 && m_kind == K_LOAD);
    e_addr = 0; e_wdata = 0; e_out = 0;
    if (m_kind == K_WORD && m_busy >= 2) e_addr = m_base + (5 - m_busy);
    if (e_ack) begin e_addr = m_ld_addr; e_wdata = m_ld_data; end
    if (e_valid) e_out = m_word;
    check("fetch_ready", fetch_ready, e_ready);
    check("instr_valid", instr_valid, e_valid);
    check("fetch_err", fetch_err, e_err);
    check("ld_ack", ld_ack, e_ack);
    check("mem_we", mem_we, e_ack);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("instr_out", instr_out, e_out);
    saw_ready = fetch_ready; saw_valid = instr_valid; saw_err = fetch_err;
    saw_ack = ld_ack; saw_out = instr_out;
    n_step++;
    @(posedge CLK);
    if (!RST_n) begin
      model_reset();
    end else if (m_busy > 0) begin
      if (m_busy == 1 && m_kind == K_LOAD) begin
        shadow[m_ld_addr] = m_ld_data;
        if (c_vld && (m_ld_addr / 4 == c_addr / 4)) c_vld = 0;
      end
      if (m_busy == 1 && m_kind == K_WORD && CACHE_ON) begin
        c_vld = 1; c_addr = m_base;
      end
      m_busy--;
    end else if (winner == 0) begin
      m_last = 0;
      m_kind = illegal(fetch_addr) ? K_ERR : K_WORD;
      if (m_kind == K_ERR) m_busy = 1;
      else begin
        m_base = fetch_addr[AW-1:0];
        m_word = word_at(int'(m_base));
        m_busy = (c_vld && c_addr == m_base) ? 1 : 5;
      end
    end else if (winner == 1) begin
      m_last = 1; m_kind = K_LOAD; m_busy = 1;
      m_ld_addr = ld_addr; m_ld_data = ld_data;
    end
    #1;
  endtask

  // ---------------- directed helpers ----------------
  task automatic do_fetch(input logic [31:0] a, output logic [31:0] w, output int lat,
                          output logic err);
    int acc = -1;
    bit done = 0;
    fetch_req = 1; fetch_addr = a; w = 0; lat = -1; err = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (saw_ready && acc < 0) acc = n_step;
      if (acc >= 0 && n_step > acc && (saw_valid || saw_err)) begin
        done = 1; w = saw_out; err = saw_err; lat = n_step - acc;
      end
    end
    fetch_req = 0;
    check("fetch_completes", 32'(done), 32'd1);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [7:0] d);
    bit done = 0;
    ld_req = 1; ld_addr = a; ld_data = d;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (saw_ack) done = 1;
    end
    ld_req = 0;
    check("load_completes", 32'(done), 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    RST_n = 0; fetch_req = 0; ld_req = 0;
    step();
    RST_n = 1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return 32'd2;
      1: return 32'd128;
      2: return $urandom;
      3, 4: return 32'($urandom_range(0, 3) * 4);
      default: return 32'($urandom_range(0, 31) * 4);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    int lat, f_cyc, a_cyc, last, nf, nl;
    logic err;
    bit alt_ok;
    logic [7:0] rom [8];
    rom = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = (i < 8) ? rom[i] : 8'($urandom);
      shadow[i] = mem[i];
    end
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    step();                       // still in reset: every output must read 0
    RST_n = 1;
    drain(2);

    // Aligned fetch of the second ROM word.
    do_fetch(32'd4, w, lat, err);
    check("word@4", w, 32'h0022_1820);
    check("lat@4", 32'(lat), 32'd5);
    check("err@4", 32'(err), 32'd0);

    // Misaligned and out-of-range fetches.
    do_fetch(32'd2, w, lat, err);
    check("err@2", 32'(err), 32'd1);
    check("errlat@2", 32'(lat), 32'd1);
    do_fetch(32'd128, w, lat, err);
    check("err@128", 32'(err), 32'd1);
    do_fetch(32'd124, w, lat, err);
    check("err@124", 32'(err), 32'd0);

    // Tie straight out of reset: fetch first, loader right after DONE.
    pulse_reset();
    fetch_req = 1; fetch_addr = 32'd8; ld_req = 1; ld_addr = 7'd9; ld_data = 8'hAA;
    f_cyc = -1; a_cyc = -1;
    for (int i = 0; i < 30 && a_cyc < 0; i++) begin
      step();
      if (saw_ready && f_cyc < 0) f_cyc = n_step;
      if (saw_valid) fetch_req = 0;
      if (saw_ack) begin a_cyc = n_step; ld_req = 0; end
    end
    fetch_req = 0; ld_req = 0;
    check("tie_fetch_first", 32'(f_cyc >= 0 && a_cyc > f_cyc), 32'd1);
    check("tie_ack_gap", 32'(a_cyc - f_cyc), 32'd7);
    do_fetch(32'd8, w, lat, err);
    check("byte9_loaded", 32'(w[23:16]), 32'hAA);
    check("lat_after_load", 32'(lat), 32'd5);

    // Both requesters permanently asserted: service must alternate.
    fetch_req = 1; fetch_addr = 32'd12; ld_req = 1; ld_addr = 7'd100; ld_data = 8'h5A;
    last = -1; nf = 0; nl = 0; alt_ok = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (saw_ready) begin if (last == 0) alt_ok = 0; last = 0; nf++; end
      if (saw_ack)   begin if (last == 1) alt_ok = 0; last = 1; nl++; end
    end
    fetch_req = 0; ld_req = 0;
    drain(8);
    check("alt_order", 32'(alt_ok), 32'd1);
    check("alt_served", 32'(nf >= 3 && nl >= 3), 32'd1);

    // Reset in the middle of a fetch (third beat), then re-issue.
    fetch_req = 1; fetch_addr = 32'd4; f_cyc = -1;
    for (int i = 0; i < 10 && f_cyc < 0; i++) begin
      step();
      if (saw_ready) f_cyc = n_step;
    end
    step(); step();               // beats 0 and 1
    RST_n = 0; fetch_req = 0;
    step();                       // beat 2, cut short by reset
    RST_n = 1;
    step();
    check("rst_no_valid", 32'(saw_valid), 32'd0);
    do_fetch(32'd4, w, lat, err);
    check("refetch_word", w, 32'h0022_1820);
    check("refetch_lat", 32'(lat), 32'd5);

    // Repeated fetch of one word, then a write into it.
    do_fetch(32'd0, w, lat, err);
    check("word@0", w, 32'h8C01_0004);
    do_fetch(32'd0, w, lat, err);
    check("word@0_again", w, 32'h8C01_0004);
    check("lat@0_again", 32'(lat), CACHE_ON ? 32'd1 : 32'd5);
    do_load(7'd2, 8'h55);
    do_fetch(32'd0, w, lat, err);
    check("word@0_updated", w, 32'h8C01_5504);
    check("lat@0_updated", 32'(lat), 32'd5);

    // Randomized traffic, with occasional resets during fetch beats.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      RST_n = 1;
      if (saw_valid || saw_err) fetch_req = 0;
      if (saw_ack) ld_req = 0;
      if (!fetch_req && $urandom_range(0, 3) == 0) begin
        fetch_req = 1; fetch_addr = pick_addr();
      end
      if (!ld_req && $urandom_range(0, 4) == 0) begin
        ld_req = 1;
        ld_addr = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom);
        ld_data = 8'($urandom);
      end
      if (m_kind == K_WORD && m_busy >= 2 && $urandom_range(0, 60) == 0) RST_n = 0;
    end
    RST_n = 1; fetch_req = 0; ld_req = 0;
    drain(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
